// File: rtl/cc_fstall_skid_pkg.sv
// Shared cache-pipeline constants for the fstall skid buffer.
// The depth limits bound how many post-stall beats a skid buffer may absorb.
package cc_fstall_skid_pkg;

  localparam int CC_WIDTH_DEFAULT      = 32;
  localparam int CC_SKID_DEPTH_MIN     = 1;
  localparam int CC_SKID_DEPTH_MAX     = 7;
  localparam int CC_SKID_DEPTH_DEFAULT = 2;

  // A single-entry buffer still needs a 1-bit pointer to keep port widths legal.
  function automatic int ccPtrWidth(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/cc_fstall_skid_ram.sv
// Register-array storage for the skid buffer: one write port, one async read port.
// Contents are cleared only by rst; a pipeline flush leaves stale data in place.
module cc_skid_ram #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 2,
  parameter int AW    = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             we_i,
  input  logic [AW-1:0]    waddr_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic [AW-1:0]    raddr_i,
  output logic [WIDTH-1:0] rdata_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/cc_fstall_skid.sv
// Output register with a small FIFO that absorbs beats arriving while fstall is high.
// Buffered beats always drain before new input reaches the output, so order is preserved.
module cc_fstall_skid
  import cc_fstall_skid_pkg::*;
#(
  parameter int WIDTH = CC_WIDTH_DEFAULT,
  parameter int DEPTH = CC_SKID_DEPTH_DEFAULT,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             except,
  input  logic             fstall,
  input  logic             in_vld,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_vld,
  output logic [WIDTH-1:0] out_data,
  output logic [CW-1:0]    count,
  output logic             overflow
);

  localparam int PW = ccPtrWidth(DEPTH);

  if (DEPTH < CC_SKID_DEPTH_MIN || DEPTH > CC_SKID_DEPTH_MAX) begin : g_depthCheck
    $error("cc_fstall_skid: DEPTH out of range");
  end

  logic             outVld_q, outVld_d;
  logic [WIDTH-1:0] outData_q, outData_d;
  logic [CW-1:0]    count_q, count_d;
  logic             overflow_q, overflow_d;
  logic [PW-1:0]    head_q, head_d;
  logic [PW-1:0]    tail_q, tail_d;
  logic             push, pop;
  logic             full, empty;
  logic [WIDTH-1:0] headData;

  assign full  = (count_q == CW'(DEPTH));
  assign empty = (count_q == '0);

  cc_skid_ram #(
    .WIDTH(WIDTH),
    .DEPTH(DEPTH),
    .AW   (PW)
  ) u_ram (
    .clk    (clk),
    .rst    (rst),
    .we_i   (push),
    .waddr_i(tail_q),
    .wdata_i(in_data),
    .raddr_i(head_q),
    .rdata_o(headData)
  );

  always_comb begin
    outVld_d   = outVld_q;
    outData_d  = outData_q;
    count_d    = count_q;
    overflow_d = overflow_q;
    head_d     = head_q;
    tail_d     = tail_q;
    push       = 1'b0;
    pop        = 1'b0;

    if (except) begin
      outVld_d   = 1'b0;
      count_d    = '0;
      overflow_d = 1'b0;
      head_d     = '0;
      tail_d     = '0;
    end else if (fstall) begin
      if (in_vld) begin
        if (full) overflow_d = 1'b1;
        else      push       = 1'b1;
      end
    end else if (!empty) begin
      // Draining frees a slot this cycle, so a push is always accepted here.
      pop       = 1'b1;
      outVld_d  = 1'b1;
      outData_d = headData;
      push      = in_vld;
    end else begin
      outVld_d = in_vld;
      if (in_vld) outData_d = in_data;
    end

    if (push) tail_d = (tail_q == PW'(DEPTH - 1)) ? '0 : tail_q + PW'(1);
    if (pop)  head_d = (head_q == PW'(DEPTH - 1)) ? '0 : head_q + PW'(1);
    if (push && !pop)      count_d = count_q + CW'(1);
    else if (pop && !push) count_d = count_q - CW'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      outVld_q   <= 1'b0;
      outData_q  <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
      head_q     <= '0;
      tail_q     <= '0;
    end else begin
      outVld_q   <= outVld_d;
      outData_q  <= outData_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
      head_q     <= head_d;
      tail_q     <= tail_d;
    end
  end

  assign out_vld  = outVld_q;
  assign out_data = outData_q;
  assign count    = count_q;
  assign overflow = overflow_q;

endmodule

// File: tb/tb_cc_fstall_skid.sv
// Scoreboard bench for cc_fstall_skid: a DEPTH=2 and a DEPTH=3 instance, driven one at a time.
// Accepted beats are queued at issue; monitors pop whenever a fresh output beat is loaded.
module tb_cc_fstall_skid;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        stall = 1'b0;
  logic        exc = 1'b0;
  logic        vld = 1'b0;
  logic [31:0] data = '0;
  int          dut = 0;

  logic        fstall2, except2, inVld2;
  logic        fstall3, except3, inVld3;
  logic        outVld2, outVld3, ovf2, ovf3;
  logic [31:0] outData2, outData3;
  logic [1:0]  count2, count3;

  int          compared = 0;
  int          mismatched = 0;
  logic [31:0] q2[$];
  logic [31:0] q3[$];

  always #5 clk = ~clk;

  assign fstall2 = (dut == 0) ? stall : 1'b0;
  assign except2 = (dut == 0) ? exc   : 1'b0;
  assign inVld2  = (dut == 0) ? vld   : 1'b0;
  assign fstall3 = (dut == 1) ? stall : 1'b0;
  assign except3 = (dut == 1) ? exc   : 1'b0;
  assign inVld3  = (dut == 1) ? vld   : 1'b0;

  cc_fstall_skid #(.WIDTH(32), .DEPTH(2)) u2 (
    .clk(clk), .rst(rst), .except(except2), .fstall(fstall2), .in_vld(inVld2),
    .in_data(data), .out_vld(outVld2), .out_data(outData2), .count(count2), .overflow(ovf2)
  );

  cc_fstall_skid #(.WIDTH(32), .DEPTH(3)) u3 (
    .clk(clk), .rst(rst), .except(except3), .fstall(fstall3), .in_vld(inVld3),
    .in_data(data), .out_vld(outVld3), .out_data(outData3), .count(count3), .overflow(ovf3)
  );

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // A new beat reaches the output only in a cycle where fstall, except and rst were all low.
  always @(posedge clk) begin
    logic sF, sE, sR;
    logic [31:0] exp;
    sF = fstall2; sE = except2; sR = rst;
    #1;
    if (!sR && !sE && !sF && outVld2) begin
      if (q2.size() == 0) begin
        compared++; mismatched++;
        $display("[TB] FAIL d2_unexpected_beat: got %0h expected none", outData2);
      end else begin
        exp = q2.pop_front();
        checkOutput("d2_beat", outData2, exp);
      end
    end
  end

  always @(posedge clk) begin
    logic sF, sE, sR;
    logic [31:0] exp;
    sF = fstall3; sE = except3; sR = rst;
    #1;
    if (!sR && !sE && !sF && outVld3) begin
      if (q3.size() == 0) begin
        compared++; mismatched++;
        $display("[TB] FAIL d3_unexpected_beat: got %0h expected none", outData3);
      end else begin
        exp = q3.pop_front();
        checkOutput("d3_beat", outData3, exp);
      end
    end
  end

  task automatic applyStimulus(input logic v, input logic [31:0] d, input logic s, input logic e,
                               input logic accept);
    @(negedge clk);
    rst = 1'b0; vld = v; data = d; stall = s; exc = e;
    if (e) begin
      if (dut == 0) q2.delete(); else q3.delete();
    end else if (accept) begin
      if (dut == 0) q2.push_back(d); else q3.push_back(d);
    end
    @(posedge clk);
    #2;
  endtask

  task automatic doReset(input logic s, input int cycles);
    @(negedge clk);
    rst = 1'b1; vld = 1'b1; data = 32'hDEAD_BEEF; stall = s; exc = 1'b0;
    q2.delete(); q3.delete();
    repeat (cycles) @(posedge clk);
    #2;
  endtask

  initial begin
    doReset(1'b0, 2);
    checkOutput("rst_out_vld", 32'(outVld2), 32'd0);
    checkOutput("rst_out_data", outData2, 32'd0);
    checkOutput("rst_count", 32'(count2), 32'd0);
    checkOutput("rst_overflow", 32'(ovf2), 32'd0);
    checkOutput("rst_count_d3", 32'(count3), 32'd0);

    // Pass-through at one-cycle latency.
    applyStimulus(1'b1, 32'hA000_0001, 1'b0, 1'b0, 1'b1);
    checkOutput("pt_vld", 32'(outVld2), 32'd1);
    checkOutput("pt_count_a", 32'(count2), 32'd0);
    applyStimulus(1'b1, 32'hB000_0002, 1'b0, 1'b0, 1'b1);
    checkOutput("pt_count_b", 32'(count2), 32'd0);
    applyStimulus(1'b1, 32'hC000_0003, 1'b0, 1'b0, 1'b1);
    checkOutput("pt_count_c", 32'(count2), 32'd0);
    applyStimulus(1'b0, 32'h1111_1111, 1'b0, 1'b0, 1'b0);
    checkOutput("idle_vld", 32'(outVld2), 32'd0);
    checkOutput("idle_data_hold", outData2, 32'hC000_0003);

    // Stall with two beats absorbed, then drain in order.
    applyStimulus(1'b1, 32'hA000_0010, 1'b0, 1'b0, 1'b1);
    applyStimulus(1'b1, 32'hB000_0011, 1'b1, 1'b0, 1'b1);
    checkOutput("st_count1", 32'(count2), 32'd1);
    checkOutput("st_hold_a1", outData2, 32'hA000_0010);
    applyStimulus(1'b1, 32'hC000_0012, 1'b1, 1'b0, 1'b1);
    checkOutput("st_count2", 32'(count2), 32'd2);
    checkOutput("st_hold_vld", 32'(outVld2), 32'd1);
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
    checkOutput("st_count2b", 32'(count2), 32'd2);
    checkOutput("st_hold_a3", outData2, 32'hA000_0010);
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    checkOutput("dr_count1", 32'(count2), 32'd1);
    checkOutput("dr_data_b", outData2, 32'hB000_0011);
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    checkOutput("dr_count0", 32'(count2), 32'd0);
    checkOutput("dr_data_c", outData2, 32'hC000_0012);
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);

    // Overflow: third stalled beat is dropped and the flag is sticky.
    applyStimulus(1'b1, 32'hB000_0020, 1'b1, 1'b0, 1'b1);
    applyStimulus(1'b1, 32'hC000_0021, 1'b1, 1'b0, 1'b1);
    checkOutput("of_pre_flag", 32'(ovf2), 32'd0);
    applyStimulus(1'b1, 32'hD000_0022, 1'b1, 1'b0, 1'b0);
    checkOutput("of_count", 32'(count2), 32'd2);
    checkOutput("of_flag", 32'(ovf2), 32'd1);
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    checkOutput("of_drained", 32'(count2), 32'd0);
    checkOutput("of_sticky", 32'(ovf2), 32'd1);
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);

    // Simultaneous push and pop keeps count at one.
    applyStimulus(1'b1, 32'hB000_0030, 1'b1, 1'b0, 1'b1);
    checkOutput("pp_count_pre", 32'(count2), 32'd1);
    applyStimulus(1'b1, 32'hC000_0031, 1'b0, 1'b0, 1'b1);
    checkOutput("pp_count", 32'(count2), 32'd1);
    checkOutput("pp_out_b", outData2, 32'hB000_0030);
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    checkOutput("pp_out_c", outData2, 32'hC000_0031);
    checkOutput("pp_count0", 32'(count2), 32'd0);

    // Flush while full and overflowed, with a beat offered in the flush cycle.
    applyStimulus(1'b1, 32'hB000_0040, 1'b1, 1'b0, 1'b1);
    applyStimulus(1'b1, 32'hC000_0041, 1'b1, 1'b0, 1'b1);
    applyStimulus(1'b1, 32'hD000_0042, 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b1, 32'hFFFF_0043, 1'b1, 1'b1, 1'b0);
    checkOutput("fl_vld", 32'(outVld2), 32'd0);
    checkOutput("fl_count", 32'(count2), 32'd0);
    checkOutput("fl_overflow", 32'(ovf2), 32'd0);
    applyStimulus(1'b1, 32'hE000_0044, 1'b0, 1'b0, 1'b1);
    checkOutput("fl_out_e", outData2, 32'hE000_0044);
    checkOutput("fl_out_e_vld", 32'(outVld2), 32'd1);

    // Flush with fstall low must not release the buffered beat.
    applyStimulus(1'b1, 32'hF000_0050, 1'b1, 1'b0, 1'b1);
    applyStimulus(1'b1, 32'hF000_0051, 1'b0, 1'b1, 1'b0);
    checkOutput("fl2_vld", 32'(outVld2), 32'd0);
    checkOutput("fl2_count", 32'(count2), 32'd0);
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    checkOutput("fl2_idle_vld", 32'(outVld2), 32'd0);

    // Reset while stalled with full storage.
    applyStimulus(1'b1, 32'h6000_0060, 1'b1, 1'b0, 1'b1);
    applyStimulus(1'b1, 32'h6000_0061, 1'b1, 1'b0, 1'b1);
    checkOutput("rs_full", 32'(count2), 32'd2);
    doReset(1'b1, 1);
    checkOutput("rs_count", 32'(count2), 32'd0);
    checkOutput("rs_vld", 32'(outVld2), 32'd0);
    checkOutput("rs_data", outData2, 32'd0);
    applyStimulus(1'b1, 32'h7000_0070, 1'b0, 1'b0, 1'b1);
    checkOutput("rs_out_h", outData2, 32'h7000_0070);
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);

    // DEPTH=3: offset pointers by one, then ten stall/drain rounds across the wrap.
    dut = 1;
    applyStimulus(1'b1, 32'h3000_00FF, 1'b1, 1'b0, 1'b1);
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    for (int r = 0; r < 10; r++) begin
      for (int k = 0; k < 3; k++) begin
        applyStimulus(1'b1, 32'h3000_0000 + 32'(r * 16 + k), 1'b1, 1'b0, 1'b1);
        checkOutput("d3_count_fill", 32'(count3), 32'(k + 1));
      end
      repeat (3) applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
      checkOutput("d3_count_drain", 32'(count3), 32'd0);
    end
    checkOutput("d3_no_overflow", 32'(ovf3), 32'd0);

    repeat (3) applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    checkOutput("d2_queue_empty", 32'(q2.size()), 32'd0);
    checkOutput("d3_queue_empty", 32'(q3.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
